alu_risc_seq: RTL and testbench

Registered, handshaked successor to the combinational RISC-SPM ALU, parametrised in word and opcode width. It keeps the NOP/ADD/SUB/AND/NOT encodings and operand conventions, and adds OR/XOR/shift ops and a full carry/negative/overflow flag set. An optional multi-cycle shift-add multiply is compiled in by macro. It sits between the datapath buses (data_1 = Reg_Y side, data_2 = Bus_1 side) and the control unit, which issues start and waits for done.

---
 rtl/alu_risc_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_risc_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_risc_seq.sv
// Registered, handshaked RISC ALU with carry/negative/overflow flags.
// Define ALU_RISC_MUL_EN to build in the multi-cycle shift-add multiplier (MUL=13).
module alu_risc_seq #(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_SIZE-1:0]   sel,
    input  logic [WORD_SIZE-1:0] data_1,
    input  logic [WORD_SIZE-1:0] data_2,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic [WORD_SIZE-1:0] alu_out_hi,
    output logic                 alu_zero_flag,
    output logic                 alu_carry_flag,
    output logic                 alu_neg_flag,
    output logic                 alu_ovf_flag,
    output logic                 busy,
    output logic                 done
);
    localparam int W = WORD_SIZE;
    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_NOT = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(9);
    localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(10);
    localparam logic [OP_SIZE-1:0] OP_SHL = OP_SIZE'(11);
    localparam logic [OP_SIZE-1:0] OP_SHR = OP_SIZE'(12);

    // Stage p0: single-cycle result and flags from the live operands
    logic [W:0]          sum_p0, diff_p0;
    logic [W-1:0]        res_p0;
    logic                carry_p0, ovf_p0, load_alu_p0;
    logic signed [W-1:0] a_s, b_s, sum_s, diff_s;

    always_comb begin
        sum_p0   = {1'b0, data_1} + {1'b0, data_2};
        diff_p0  = {1'b0, data_2} - {1'b0, data_1};
        a_s      = data_1;
        b_s      = data_2;
        sum_s    = sum_p0[W-1:0];
        diff_s   = diff_p0[W-1:0];
        res_p0   = '0;
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
        case (sel)
            OP_ADD: begin
                res_p0   = sum_p0[W-1:0];
                carry_p0 = sum_p0[W];
                ovf_p0   = ((a_s < 0) == (b_s < 0)) && ((sum_s < 0) != (a_s < 0));
            end
            OP_SUB: begin
                res_p0   = diff_p0[W-1:0];
                carry_p0 = diff_p0[W];
                ovf_p0   = ((a_s < 0) != (b_s < 0)) && ((diff_s < 0) != (b_s < 0));
            end
            OP_AND: res_p0 = data_1 & data_2;
            OP_NOT: res_p0 = ~data_2;
            OP_OR:  res_p0 = data_1 | data_2;
            OP_XOR: res_p0 = data_1 ^ data_2;
            OP_SHL: begin
                res_p0   = {data_2[W-2:0], 1'b0};
                carry_p0 = data_2[W-1];
            end
            OP_SHR: begin
                res_p0   = {1'b0, data_2[W-1:1]};
                carry_p0 = data_2[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_RISC_MUL_EN
    localparam logic [OP_SIZE-1:0] OP_MUL = OP_SIZE'(13);
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t state, state_nxt;

    logic [2*W-1:0] mcand_p1, prod_p1, prod_nxt;
    logic [W-1:0]   mplier_p1, out_hi_q;
    logic [CNT_W-1:0] cnt_p1;
    logic           accept_mul, mul_last;

    assign accept_mul  = (state == IDLE) && start && (sel == OP_MUL);
    assign load_alu_p0 = (state == IDLE) && start && (sel != OP_MUL);
    assign mul_last    = (state == MUL_RUN) && (cnt_p1 == CNT_LAST);
    assign prod_nxt    = prod_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    assign alu_out_hi  = out_hi_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_mul) state_nxt = MUL_RUN;
            MUL_RUN: if (mul_last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MUL_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst)                   cnt_p1 <= '0;
        else if (accept_mul)       cnt_p1 <= '0;
        else if (state == MUL_RUN) cnt_p1 <= cnt_p1 + 1'b1;
    end

    // Stage p1: shift-add datapath, multiplicand moves left as multiplier bits retire
    always_ff @(posedge clk) begin
        if (accept_mul) begin
            mcand_p1  <= {{W{1'b0}}, data_1};
            mplier_p1 <= data_2;
            prod_p1   <= '0;
        end else if (state == MUL_RUN) begin
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            prod_p1   <= prod_nxt;
        end
    end
`else
    assign load_alu_p0 = start;
    assign busy        = 1'b0;
    assign alu_out_hi  = '0;
`endif

    // Stage p2: architectural result and flags, held until the next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out        <= '0;
            alu_zero_flag  <= 1'b1;
            alu_carry_flag <= 1'b0;
            alu_neg_flag   <= 1'b0;
            alu_ovf_flag   <= 1'b0;
            done           <= 1'b0;
`ifdef ALU_RISC_MUL_EN
            out_hi_q       <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load_alu_p0) begin
                alu_out        <= res_p0;
                alu_zero_flag  <= ~|res_p0;
                alu_carry_flag <= carry_p0;
                alu_neg_flag   <= res_p0[W-1];
                alu_ovf_flag   <= ovf_p0;
                done           <= 1'b1;
`ifdef ALU_RISC_MUL_EN
                out_hi_q       <= '0;
            end else if (mul_last) begin
                alu_out        <= prod_nxt[W-1:0];
                out_hi_q       <= prod_nxt[2*W-1:W];
                alu_zero_flag  <= ~|prod_nxt[W-1:0];
                alu_carry_flag <= |prod_nxt[2*W-1:W];
                alu_neg_flag   <= prod_nxt[W-1];
                alu_ovf_flag   <= 1'b0;
                done           <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_risc_seq.sv
// Bench for alu_risc_seq: cycle model from the opcode rules plus directed literal checks.
// MUL checks are included when ALU_RISC_MUL_EN is defined.
module tb_alu_risc_seq;
    localparam int W = 8;
`ifdef ALU_RISC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk, rst, start;
    logic [3:0]   sel;
    logic [W-1:0] data_1, data_2, alu_out, alu_out_hi;
    logic         alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag, busy, done;

    alu_risc_seq #(.WORD_SIZE(W), .OP_SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .data_1(data_1), .data_2(data_2),
        .alu_out(alu_out), .alu_out_hi(alu_out_hi),
        .alu_zero_flag(alu_zero_flag), .alu_carry_flag(alu_carry_flag),
        .alu_neg_flag(alu_neg_flag), .alu_ovf_flag(alu_ovf_flag),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         z, c, n, v;
    } res_t;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one operation, straight from the opcode table.
    function automatic res_t eval(input int op, input int a, input int b);
        res_t e;
        int lim = 1 << W;
        int sa = (a >= lim / 2) ? a - lim : a;
        int sb = (b >= lim / 2) ? b - lim : b;
        int r = 0, hi = 0, s;
        bit c = 1'b0, v = 1'b0;
        case (op)
            1: begin r = a + b; c = (r >= lim); s = sa + sb; v = (s > lim / 2 - 1) || (s < -lim / 2); end
            2: begin r = b - a; c = (r < 0); s = sb - sa; v = (s > lim / 2 - 1) || (s < -lim / 2); end
            3: r = a & b;
            4: r = lim - 1 - b;
            9: r = a | b;
            10: r = a ^ b;
            11: begin r = b * 2; c = (b >= lim / 2); end
            12: begin r = b / 2; c = (b % 2) == 1; end
            13: if (MUL_EN) begin r = a * b; hi = r / lim; c = (hi != 0); end
            default: r = 0;
        endcase
        r = ((r % lim) + lim) % lim;
        e.out = W'(r);
        e.hi  = W'(hi);
        e.z   = (r == 0);
        e.c   = c;
        e.n   = (r >= lim / 2);
        e.v   = v;
        return e;
    endfunction

    res_t m_res, m_pend;
    bit   m_done = 1'b0;
    int   m_left = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_res  <= res_t'{out: '0, hi: '0, z: 1'b1, c: 1'b0, n: 1'b0, v: 1'b0};
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res  <= m_pend;
                m_done <= 1'b1;
            end
        end else if (start) begin
            if (MUL_EN && sel == 4'd13) begin
                m_left <= W;
                m_pend <= eval(13, int'(data_1), int'(data_2));
            end else begin
                m_res  <= eval(int'(sel), int'(data_1), int'(data_2));
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_out",   32'(alu_out),        32'(m_res.out));
            check("mdl_hi",    32'(alu_out_hi),     32'(m_res.hi));
            check("mdl_zero",  32'(alu_zero_flag),  32'(m_res.z));
            check("mdl_carry", 32'(alu_carry_flag), 32'(m_res.c));
            check("mdl_neg",   32'(alu_neg_flag),   32'(m_res.n));
            check("mdl_ovf",   32'(alu_ovf_flag),   32'(m_res.v));
            check("mdl_done",  32'(done),           32'(m_done));
            check("mdl_busy",  32'(busy),           32'(m_left > 0));
        end
    end

    // Called just after a negedge; returns one cycle later, after the accepting edge.
    task automatic issue(input int op, input int a, input int b);
        start  = 1'b1;
        sel    = 4'(op);
        data_1 = W'(a);
        data_2 = W'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int expect_cycles, input int already);
        int cyc = already;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(cyc), 32'(expect_cycles));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"},   32'(alu_out),        32'h0);
        check({tag, "_hi"},    32'(alu_out_hi),     32'h0);
        check({tag, "_zero"},  32'(alu_zero_flag),  32'h1);
        check({tag, "_carry"}, 32'(alu_carry_flag), 32'h0);
        check({tag, "_neg"},   32'(alu_neg_flag),   32'h0);
        check({tag, "_ovf"},   32'(alu_ovf_flag),   32'h0);
        check({tag, "_busy"},  32'(busy),           32'h0);
        check({tag, "_done"},  32'(done),           32'h0);
    endtask

    int b2b_op[8] = '{1, 2, 3, 9, 10, 11, 12, 4};
    int b2b_a[8]  = '{8'h55, 8'h80, 8'hF0, 8'h0F, 8'hAA, 8'h00, 8'h00, 8'h00};
    int b2b_b[8]  = '{8'hAB, 8'h7F, 8'h3C, 8'hF0, 8'hFF, 8'h40, 8'h80, 8'h00};

    initial begin
        rst = 1'b1; start = 1'b0; sel = '0; data_1 = '0; data_2 = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(1, 8'hF0, 8'h20);
        check("add_c_out", 32'(alu_out), 32'h10);
        check("add_c_carry", 32'(alu_carry_flag), 32'h1);
        check("add_c_zero", 32'(alu_zero_flag), 32'h0);
        check("add_c_ovf", 32'(alu_ovf_flag), 32'h0);
        check("add_c_done", 32'(done), 32'h1);
        @(negedge clk);
        check("add_c_done_drop", 32'(done), 32'h0);

        issue(1, 8'h7F, 8'h01);
        check("add_v_out", 32'(alu_out), 32'h80);
        check("add_v_neg", 32'(alu_neg_flag), 32'h1);
        check("add_v_ovf", 32'(alu_ovf_flag), 32'h1);
        check("add_v_carry", 32'(alu_carry_flag), 32'h0);

        issue(2, 8'h01, 8'h00);
        check("sub_b_out", 32'(alu_out), 32'hFF);
        check("sub_b_carry", 32'(alu_carry_flag), 32'h1);
        check("sub_b_neg", 32'(alu_neg_flag), 32'h1);
        check("sub_b_ovf", 32'(alu_ovf_flag), 32'h0);

        issue(2, 8'h05, 8'h05);
        check("sub_z_out", 32'(alu_out), 32'h0);
        check("sub_z_zero", 32'(alu_zero_flag), 32'h1);

        issue(11, 8'h00, 8'h81);
        check("shl_out", 32'(alu_out), 32'h02);
        check("shl_carry", 32'(alu_carry_flag), 32'h1);

        issue(5, 8'h12, 8'h34);
        check("rd_out", 32'(alu_out), 32'h0);
        check("rd_zero", 32'(alu_zero_flag), 32'h1);
        check("rd_done", 32'(done), 32'h1);

        issue(12, 8'h00, 8'h03);
        check("shr_out", 32'(alu_out), 32'h01);
        check("shr_carry", 32'(alu_carry_flag), 32'h1);

        issue(2, 8'h01, 8'h80);
        check("sub_v_out", 32'(alu_out), 32'h7F);
        check("sub_v_ovf", 32'(alu_ovf_flag), 32'h1);

        for (int i = 0; i < 8; i++) begin
            start = 1'b1; sel = 4'(b2b_op[i]);
            data_1 = W'(b2b_a[i]); data_2 = W'(b2b_b[i]);
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_not_out", 32'(alu_out), 32'hFF);

        issue(15, 8'hFF, 8'hFF);
        check("op15_out", 32'(alu_out), 32'h0);
        @(negedge clk);

`ifdef ALU_RISC_MUL_EN
        issue(13, 8'h0F, 8'h11);
        check("mul_busy", 32'(busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        issue(1, 8'h01, 8'h01);
        check("mul_ignore_out", 32'(alu_out), 32'h0);
        wait_done("mul_latency", 8, 3);
        check("mul_out", 32'(alu_out), 32'hFF);
        check("mul_hi", 32'(alu_out_hi), 32'h00);
        check("mul_carry", 32'(alu_carry_flag), 32'h0);
        @(negedge clk);

        issue(13, 8'hFF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mul_abort");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(13, 8'hFF, 8'hFF);
        wait_done("mul2_latency", 8, 0);
        check("mul2_out", 32'(alu_out), 32'h01);
        check("mul2_hi", 32'(alu_out_hi), 32'hFE);
        check("mul2_carry", 32'(alu_carry_flag), 32'h1);
        issue(1, 8'h02, 8'h03);
        check("post_mul_hi", 32'(alu_out_hi), 32'h0);
        check("post_mul_out", 32'(alu_out), 32'h05);
`else
        issue(1, 8'h01, 8'h01);
        check("pre_mul_out", 32'(alu_out), 32'h02);
        issue(13, 8'h05, 8'h07);
        check("nomul_out", 32'(alu_out), 32'h0);
        check("nomul_zero", 32'(alu_zero_flag), 32'h1);
        check("nomul_done", 32'(done), 32'h1);
        check("nomul_busy", 32'(busy), 32'h0);
        check("nomul_hi", 32'(alu_out_hi), 32'h0);
`endif
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
